// File: rtl/alu8_sched_pkg.sv
// Shared types for the alu8_sched scheduler: opcodes, FSM states, ALU control word.
package alu8_sched_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SLT  = 3'b100,
        OP_NOR  = 3'b101,
        OP_NAND = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [1:0] op;
    } alu_ctrl_t;

endpackage

// File: rtl/ALU_8bit.sv
// 8-bit ripple-carry ALU: AND/OR/ADD/SLT on optionally inverted operands.
// Carry-in equals binvert; SLT uses sign xor overflow so it stays correct across overflow.
module ALU_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] op,
    output logic [7:0] result,
    output logic       zero,
    output logic       overflow
);
    logic [7:0] ax;
    logic [7:0] bx;
    logic [7:0] sum;
    logic [8:0] carry;
    logic       set;

    always_comb begin
        ax       = a ^ {8{ainvert}};
        bx       = b ^ {8{binvert}};
        carry    = '0;
        sum      = '0;
        carry[0] = binvert;
        for (int i = 0; i < 8; i++) begin
            sum[i]     = ax[i] ^ bx[i] ^ carry[i];
            carry[i+1] = (ax[i] & bx[i]) | (ax[i] & carry[i]) | (bx[i] & carry[i]);
        end
        overflow = carry[7] ^ carry[8];
        set      = sum[7] ^ overflow;
        case (op)
            2'b00:   result = ax & bx;
            2'b01:   result = ax | bx;
            2'b10:   result = sum;
            default: result = {7'b0, set};
        endcase
        zero = (result == 8'h00);
    end

endmodule

// File: rtl/alu8_op_decode.sv
// Opcode to ALU control decode, with arithmetic and reserved-opcode flags.
module alu8_op_decode
    import alu8_sched_pkg::*;
(
    input  alu_op_e   op,
    output alu_ctrl_t ctrl,
    output logic      is_arith,
    output logic      is_rsvd
);
    always_comb begin
        ctrl     = '0;
        is_arith = 1'b0;
        is_rsvd  = 1'b0;
        case (op)
            OP_AND:  ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: 2'b00};
            OP_OR:   ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: 2'b01};
            OP_ADD: begin
                ctrl     = '{ainvert: 1'b0, binvert: 1'b0, op: 2'b10};
                is_arith = 1'b1;
            end
            OP_SUB: begin
                ctrl     = '{ainvert: 1'b0, binvert: 1'b1, op: 2'b10};
                is_arith = 1'b1;
            end
            OP_SLT:  ctrl = '{ainvert: 1'b0, binvert: 1'b1, op: 2'b11};
            OP_NOR:  ctrl = '{ainvert: 1'b1, binvert: 1'b1, op: 2'b00};
            OP_NAND: ctrl = '{ainvert: 1'b1, binvert: 1'b1, op: 2'b01};
            default: is_rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu8_sched.sv
// Two-requester scheduler in front of a single ALU_8bit instance.
// Define ALU8_SCHED_RR_EN for round-robin arbitration; fixed priority (req 0 wins) otherwise.
module alu8_sched
    import alu8_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);
    sched_state_e state, state_nxt;
    logic [NREQ-1:0]          grant;
    logic                     sel_id;
    alu_ctrl_t                sel_ctrl;
    logic                     sel_arith;
    logic                     sel_rsvd;

    alu_ctrl_t                ctrl_p0;
    logic                     arith_p0;
    logic                     rsvd_p0;
    logic                     id_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;

    logic [DATA_W-1:0]        alu_result;
    logic                     alu_zero;
    logic                     alu_ovf;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef ALU8_SCHED_RR_EN
    // prio names the requester that wins a tie; it flips away from each grantee.
    logic prio;

    always_comb begin
        grant = '0;
        if (req_valid[prio])
            grant[prio] = 1'b1;
        else if (req_valid[~prio])
            grant[~prio] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            prio <= 1'b0;
        else if (|req_ready)
            prio <= ~sel_id;
    end
`else
    always_comb begin
        grant    = '0;
        grant[0] = req_valid[0];
        grant[1] = req_valid[1] & ~req_valid[0];
    end
`endif

    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign sel_id    = grant[1];
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    alu8_op_decode u_decode (
        .op       (alu_op_e'(sel_id ? req_op1 : req_op0)),
        .ctrl     (sel_ctrl),
        .is_arith (sel_arith),
        .is_rsvd  (sel_rsvd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_ready) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // p0: operands and decoded controls latched on request handshake
    always_ff @(posedge clk) begin
        if (|req_ready) begin
            ctrl_p0  <= sel_ctrl;
            arith_p0 <= sel_arith;
            rsvd_p0  <= sel_rsvd;
            id_p0    <= sel_id;
            a_p0     <= sel_id ? req_a1 : req_a0;
            b_p0     <= sel_id ? req_b1 : req_b0;
        end
    end

    ALU_8bit u_alu (
        .a        (a_p0),
        .b        (b_p0),
        .ainvert  (ctrl_p0.ainvert),
        .binvert  (ctrl_p0.binvert),
        .op       (ctrl_p0.op),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_ovf)
    );

    // p1: response registers captured at the end of EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id     <= id_p0;
            rsp_result <= rsvd_p0 ? '0 : alu_result;
            rsp_zero   <= rsvd_p0 ? 1'b1 : alu_zero;
            rsp_ovf    <= alu_ovf & arith_p0 & ~rsvd_p0;
            rsp_err    <= rsvd_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ops_done <= '0;
        else if (state == RESP && rsp_ready)
            ops_done <= sat_inc(ops_done);
    end

endmodule

// File: tb/tb_alu8_sched.sv
// Directed self-checking bench for alu8_sched (honours ALU8_SCHED_RR_EN like the RTL).
module tb_alu8_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0, req_op1;
    logic [7:0]  req_a0, req_b0, req_a1, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_zero, rsp_ovf, rsp_err, busy;
    logic [15:0] ops_done;

    int errors = 0;
    int checks = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    alu8_sched #(.NREQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[id] = 1'b1;
    endtask

    // Called just after a negedge with the request driven; returns just after the negedge
    // in which the handshake is pending for the next posedge.
    task automatic wait_ready(input int id, input string tag);
        int n = 0;
        #1;
        while (!req_ready[id] && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, {31'b0, req_ready[id]}, 32'd1);
    endtask

    task automatic do_op(input string tag, input int id, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                         input logic z, input logic o, input logic e);
        @(negedge clk);
        set_req(id, op, a, b);
        wait_ready(id, tag);
        @(negedge clk);
        req_valid[id] = 1'b0;
        chk({tag, "_exec_vld"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_id"}, {31'b0, rsp_id}, id);
        chk({tag, "_res"}, {24'b0, rsp_result}, {24'b0, res});
        chk({tag, "_zero"}, {31'b0, rsp_zero}, {31'b0, z});
        chk({tag, "_ovf"}, {31'b0, rsp_ovf}, {31'b0, o});
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e});
        @(negedge clk);
        exp_done++;
        chk({tag, "_done"}, {16'b0, ops_done}, exp_done);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic dbl;
        logic [1:0] exp_id;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_op0 = 3'd2; req_op1 = 3'd2;
        req_a0 = 8'h11; req_b0 = 8'h22; req_a1 = 8'h33; req_b1 = 8'h44;
        repeat (3) @(negedge clk);

        // reset state, with both requests asserted to show ready is held low
        chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
        chk("rst_rsp_result", {24'b0, rsp_result}, 32'd0);
        chk("rst_rsp_zero", {31'b0, rsp_zero}, 32'd0);
        chk("rst_rsp_ovf", {31'b0, rsp_ovf}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ops_done", {16'b0, ops_done}, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        do_op("add",   0, 3'b010, 8'd100, 8'd50, 8'h96, 1'b0, 1'b1, 1'b0);
        do_op("sub",   1, 3'b011, 8'd5,   8'd5,  8'h00, 1'b1, 1'b0, 1'b0);
        do_op("nor",   0, 3'b101, 8'h0F,  8'hF0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("slt1",  1, 3'b100, 8'hFD,  8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("slt2",  0, 3'b100, 8'h80,  8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("slt3",  1, 3'b100, 8'h7F,  8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("or",    1, 3'b001, 8'h12,  8'h21, 8'h33, 1'b0, 1'b0, 1'b0);
        do_op("and",   0, 3'b000, 8'hF0,  8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op("nand",  1, 3'b110, 8'hFF,  8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("sub_ov",0, 3'b011, 8'h80,  8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op("rsvd",  0, 3'b111, 8'h55,  8'h55, 8'h00, 1'b1, 1'b0, 1'b1);

        // contention: both valid continuously, four responses
        do_reset();
        @(negedge clk);
        set_req(0, 3'b010, 8'd1, 8'd1);
        set_req(1, 3'b001, 8'd3, 8'd4);
        dbl = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU8_SCHED_RR_EN
            exp_id = 2'(k % 2);
`else
            exp_id = 2'd0;
`endif
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 10) begin
                if (req_ready == 2'b11) dbl = 1'b1;
                @(negedge clk);
                n++;
            end
            chk("cont_vld", {31'b0, rsp_valid}, 32'd1);
            chk("cont_id", {31'b0, rsp_id}, {30'b0, exp_id});
            chk("cont_res", {24'b0, rsp_result}, exp_id[0] ? 32'h07 : 32'h02);
        end
        @(negedge clk);
        req_valid = 2'b00;
        chk("cont_one_hot", {31'b0, dbl}, 32'd0);
        chk("cont_done", {16'b0, ops_done}, 32'd4);
        exp_done = 4;

        // backpressure: hold RESP for 5 cycles with the other requester waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 3'b000, 8'hF0, 8'h3C);
        wait_ready(0, "bp");
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, 3'b001, 8'h01, 8'h02);
        @(negedge clk);
        chk("bp_vld0", {31'b0, rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_vld", {31'b0, rsp_valid}, 32'd1);
            chk("bp_res", {24'b0, rsp_result}, 32'h30);
            chk("bp_id", {31'b0, rsp_id}, 32'd0);
            chk("bp_ready", {30'b0, req_ready}, 32'd0);
            chk("bp_done_hold", {16'b0, ops_done}, exp_done);
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        exp_done++;
        chk("bp_done_inc", {16'b0, ops_done}, exp_done);
        chk("bp_released", {31'b0, rsp_valid}, 32'd0);

        // reset while in EXEC discards the operation
        @(negedge clk);
        set_req(1, 3'b010, 8'd1, 8'd2);
        wait_ready(1, "rx");
        @(negedge clk);
        chk("rx_busy_exec", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rx_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rx_busy", {31'b0, busy}, 32'd0);
        chk("rx_rsp_result", {24'b0, rsp_result}, 32'd0);
        chk("rx_rsp_id", {31'b0, rsp_id}, 32'd0);
        chk("rx_rsp_zero", {31'b0, rsp_zero}, 32'd0);
        chk("rx_rsp_ovf", {31'b0, rsp_ovf}, 32'd0);
        chk("rx_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rx_ops_done", {16'b0, ops_done}, 32'd0);
        chk("rx_req_ready", {30'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        dbl = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) dbl = 1'b1;
        end
        chk("rx_no_rsp", {31'b0, dbl}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu8_sched.md
# alu8_sched

Two-requester scheduler for the shared 8-bit ripple ALU (`ALU_8bit`). It arbitrates between two request channels and decodes a 3-bit opcode into the ALU's `Ainvert`/`Binvert`/`op` controls. Operands are registered into the ALU. The result, `zero` and `overflow` are captured and returned on a shared valid/ready response channel tagged with the requester id. It sits between the instruction-sequencing logic and the single ALU instance, so the ALU is never driven by two sources.

## Interface
- `NREQ`, 2: number of requesters. Fixed at 2; other values are unsupported.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in [1:0]: request valid, one bit per requester.
- `req_ready` out [1:0]: request accepted, one bit per requester.
- `req_op0`, `req_op1` in 3: opcode per requester.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 8: operands per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out 1: requester that owns the response.
- `rsp_result` out 8: ALU result.
- `rsp_zero` out 1: result == 0.
- `rsp_ovf` out 1: signed overflow; forced to 0 for non-ADD/SUB ops.
- `rsp_err` out 1: reserved opcode was issued.
- `busy` out 1: FSM not in IDLE.
- `ops_done` out CNT_W: saturating count of completed responses.

## Operation

Opcodes:
- 000 AND: Ai=0, Bi=0, op=00
- 001 OR: Ai=0, Bi=0, op=01
- 010 ADD: Ai=0, Bi=0, op=10
- 011 SUB: Ai=0, Bi=1, op=10
- 100 SLT: Ai=0, Bi=1, op=11
- 101 NOR: Ai=1, Bi=1, op=00
- 110 NAND: Ai=1, Bi=1, op=01
- 111 reserved: ALU is not consulted. Response has result 0x00, zero=1, ovf=0, err=1.

FSM states:
- IDLE: `req_ready[i]` = 1 only for the granted requester, and only while it has `req_valid[i]`=1. On handshake, latch op, a, b and id, then go to EXEC.
- EXEC: registered operands and decoded controls drive the ALU. At the end of this cycle, capture result, zero and masked overflow into response registers. Go to RESP.
- RESP: hold `rsp_valid`=1 with stable fields until `rsp_ready`. On handshake, increment `ops_done` (saturate at all-ones) and go to IDLE.

Arbitration and handshake rules:
- Grant is combinational from `req_valid` and the priority state.
- At most one `req_ready` bit is high in any cycle.
- Requesters must hold op and operands stable while `req_valid` is high and not yet accepted.
- SLT correctness for signed overflow (e.g. -128 < 127) comes from the ALU's internal less-correction. The scheduler adds no fix-up.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_ovf`=0, `rsp_err`=0, `busy`=0, `ops_done`=0, state=IDLE, priority pointer=requester 0.
- Latency: a request accepted in cycle N gives `rsp_valid`=1 in cycle N+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with `rsp_ready`=1). No new request is accepted outside IDLE.
- Response backpressure: RESP holds indefinitely. Requesters stall with `req_ready`=0.
- Both requesters valid in the same cycle: one is granted per the configured policy. The loser keeps `req_valid` and is served next time the FSM is in IDLE.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded with no response. All outputs return to their reset values on the next edge.

## Configuration
- `ALU8_SCHED_RR_EN` defined: round-robin arbitration.
  - The pointer moves to the other requester after each grant.
  - On simultaneous requests, the non-last-granted requester wins.
- `ALU8_SCHED_RR_EN` undefined: fixed priority. Requester 0 always wins ties, and no pointer register exists.

## Structure
- Package `alu8_sched_pkg`:
  - opcode enum `alu_op_e` (OP_AND … OP_RSVD);
  - FSM state enum `sched_state_e` (IDLE, EXEC, RESP);
  - struct `alu_ctrl_t` {ainvert, binvert, op[1:0]}.
- Sub-module `alu8_op_decode`: purely combinational, opcode to `alu_ctrl_t`, plus an `is_arith` flag (for overflow masking) and an `is_rsvd` flag.
- One `ALU_8bit` instance inside the scheduler. It is driven only from the operand and control registers.

## Test plan
- ADD: req0 with a=100, b=50 -> response in cycle N+2 with result=0x96, ovf=1, zero=0, id=0.
- SUB and NOR:
  - req1 SUB with 5, 5 -> result=0x00, zero=1, ovf=0, id=1.
  - NOR with 0x0F, 0xF0 -> result 0x00, zero=1, ovf=0.
- SLT:
  - 0xFD vs 0x02 -> result=0x01.
  - 0x80 vs 0x7F -> result=0x01.
  - 0x7F vs 0x80 -> result=0x00.
- Contention: both requesters valid continuously, 4 ops, `rsp_ready`=1.
  - With `ALU8_SCHED_RR_EN`, grant ids are 0, 1, 0, 1.
  - Without it, grant ids are 0, 0, 0, 0.
- Backpressure: `rsp_ready`=0 for 5 cycles.
  - Response fields stay stable, and `req_ready`=0 throughout.
  - After `rsp_ready` rises, `ops_done` increments by 1.
- Reserved opcode and reset:
  - Opcode 111 -> result 0x00, err=1, zero=1.
  - `rst_n`=0 during EXEC -> no response, and all outputs reset next edge.
